vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1 bit, pixel clock (25.175 MHz nominal); the block uses one clock.
REQ-010 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-011 SHALL have port ena, input, 1 bit, counter advance enable.
REQ-012 SHALL have port x, output, 10 bits, current horizontal count, 0..H_TOTAL-1.
REQ-013 SHALL have port y, output, 10 bits, current vertical count, 0..V_TOTAL-1.
REQ-014 SHALL have port active, output, 1 bit, high when the pixel is in the visible area.
REQ-015 SHALL have port hsync, output, 1 bit, horizontal sync, active-low.
REQ-016 SHALL have port vsync, output, 1 bit, vertical sync, active-low.
REQ-017 SHALL have port frame_start, output, 1 bit, one-cycle pulse at frame origin.
REQ-018 SHALL have port frame_count, output, 8 bits, completed-frame counter.

Function
REQ-019 SHALL define H_TOTAL as the sum of the four H parameters (800) and V_TOTAL as the sum of the four V parameters (525).
REQ-020 SHALL increment x by 1 on each rising clk edge with ena=1; the increment after x=H_TOTAL-1 SHALL set x to 0.
REQ-021 SHALL increment y by 1 only on a cycle where x wraps; the increment after y=V_TOTAL-1 SHALL set y to 0.
REQ-022 SHALL hold x, y, frame_count and all sync state unchanged while ena=0; frame_start SHALL be 0 while ena=0.
REQ-023 SHALL drive active = (x < H_VISIBLE) and (y < V_VISIBLE).
REQ-024 SHALL drive hsync=0 exactly for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise hsync=1.
REQ-025 SHALL drive vsync=0 exactly for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the full line, regardless of x; otherwise vsync=1.
REQ-026 SHALL assert frame_start for exactly one clk cycle, the cycle in which (x,y) first equals (0,0) after a full-frame wrap from (H_TOTAL-1,V_TOTAL-1).
REQ-027 SHALL increment frame_count modulo 256 on the same edge on which frame_start rises; the increment after 255 SHALL set frame_count to 0.
REQ-028 SHALL register x and y; x, y and frame_count SHALL never exceed their stated ranges.

Reset
REQ-029 SHALL asynchronously force x=0, y=0, frame_count=0 and frame_start=0 while rst_n=0, independent of clk and ena.
REQ-030 SHALL drive hsync=1 and vsync=1 while rst_n=0.
REQ-031 SHALL resume counting from (0,0) on the first enabled edge after rst_n rises; a reset mid-line or mid-frame SHALL NOT produce a frame_start pulse.

Configuration
REQ-032 SHALL compile in an output alignment stage when macro VGA_SYNC_DELAY_EN is defined: active, hsync and vsync are registered and lag x,y by exactly one enabled clk cycle, matching a one-stage registered pixel pipeline; the stage resets to active=0, hsync=1, vsync=1.
REQ-033 SHALL, without VGA_SYNC_DELAY_EN, decode active, hsync and vsync from the same cycle's x,y with zero lag; active SHALL equal 1 during reset.

Verification
REQ-034 SHALL cover the line sweep: reset release, ena=1 -> hsync falls when x=656, rises when x=752; x wraps 799->0 and y increments 0->1.
REQ-035 SHALL cover the vsync window: run to y=489, x=799 -> vsync=0 for all of y=490 and y=491, vsync=1 at y=492, x=0.
REQ-036 SHALL cover frame wrap: (799,524) -> next cycle (0,0) with frame_start=1 for one cycle and frame_count 0->1; also preload to 255 -> rolls to 0.
REQ-037 SHALL cover the enable stall: ena=0 for 10 cycles at x=300, y=100 -> x,y,frame_count unchanged and frame_start=0; resume -> x=301.
REQ-038 SHALL cover reset mid-operation: rst_n=0 at x=400, y=250 -> immediately x=0, y=0, hsync=1, vsync=1, frame_start=0; no pulse on release.
REQ-039 SHALL cover the macro build: with VGA_SYNC_DELAY_EN, hsync falls one cycle after x=656 and active falls one cycle after x=640.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                               |
// | Description : VGA raster timing generator. Counts pixels (x) and lines (y) |
// |               over a full frame including porches and sync. It decodes     |
// |               active/hsync/vsync, and it pulses frame_start at each frame  |
// |               origin. It also counts completed frames.                     |
// | Ports       : clk          - pixel clock                                   |
// |               rst_n        - asynchronous active-low reset                 |
// |               ena          - advance enable (counters hold when low)       |
// |               x, y         - current horizontal / vertical position        |
// |               active       - pixel lies in the visible area                |
// |               hsync, vsync - active-low sync pulses                        |
// |               frame_start  - one-cycle pulse at (0,0) after a frame wrap   |
// |               frame_count  - completed frames, modulo 256                  |
// | Options     : VGA_SYNC_DELAY_EN - register active/hsync/vsync so that they |
// |               lag x,y by one enabled cycle (registered pixel pipeline)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] X_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] X_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] Y_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] Y_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic       fs_q, fs_d;
  logic       x_wrap;
  logic       frame_wrap;
  logic       active_w, hsync_w, vsync_w;

  // Next-state logic for the raster counters and the frame bookkeeping.
  always_comb begin
    x_wrap     = (x_q == X_LAST);
    frame_wrap = x_wrap && (y_q == Y_LAST);
    x_d        = x_q;
    y_d        = y_q;
    fc_d       = fc_q;
    fs_d       = fs_q;
    if (ena) begin
      x_d = x_wrap ? 10'd0 : x_q + 10'd1;
      if (x_wrap) begin
        y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end
      // The pulse flag is armed only by a genuine frame wrap, so a reset
      // (which also lands on (0,0)) never arms it.
      fs_d = frame_wrap;
      if (frame_wrap) begin
        fc_d = fc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= 10'd0;
      y_q  <= 10'd0;
      fc_q <= 8'd0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
      fs_q <= fs_d;
    end
  end

  // Position decode from the current counter values.
  always_comb begin
    active_w = (x_q < X_VIS_END) && (y_q < Y_VIS_END);
    hsync_w  = !((x_q >= X_HS_START) && (x_q < X_HS_END));
    vsync_w  = !((y_q >= Y_VS_START) && (y_q < Y_VS_END));
  end

`ifdef VGA_SYNC_DELAY_EN
  logic active_q, hsync_q, vsync_q;

  // Alignment stage: advances only with the counters so the lag stays at
  // exactly one enabled cycle even across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else if (ena) begin
      active_q <= active_w;
      hsync_q  <= hsync_w;
      vsync_q  <= vsync_w;
    end
  end

  assign active = active_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
`else
  assign active = active_w;
  assign hsync  = hsync_w;
  assign vsync  = vsync_w;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign frame_count = fc_q;
  // The flag stays armed through a stall and is shown only in the first enabled
  // cycle at the origin. That cycle's edge then clears it.
  assign frame_start = fs_q & ena;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                            |
// | Description : Self-checking bench for vga_timing_gen. The bench has one    |
// |               instance with default timing and one small-raster instance   |
// |               used for frame wrap and frame_count rollover. A linear       |
// |               pixel-index model checks every cycle.                        |
// | Options     : VGA_SYNC_DELAY_EN selects the one-cycle-lag expectations     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit LAG = 1'b1;
`else
  localparam bit LAG = 1'b0;
`endif

  localparam int S_HV = 4, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int S_VV = 3, S_VF = 1, S_VS = 2, S_VB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_act, d_hs, d_vs, d_fs, s_act, s_hs, s_vs, s_fs;
  logic [7:0] d_fc, s_fc;

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(d_x), .y(d_y), .active(d_act),
    .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ena(ena), .x(s_x), .y(s_y), .active(s_act),
    .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .frame_count(s_fc)
  );

  int compared = 0;
  int mismatched = 0;

  // Raster geometry per instance.
  int hv[2] = '{640, S_HV};
  int hf[2] = '{16, S_HF};
  int hs[2] = '{96, S_HS};
  int ht[2] = '{640 + 16 + 96 + 48, S_HV + S_HF + S_HS + S_HB};
  int vv[2] = '{480, S_VV};
  int vf[2] = '{10, S_VF};
  int vs[2] = '{2, S_VS};
  int vt[2] = '{480 + 10 + 2 + 33, S_VV + S_VF + S_VS + S_VB};

  // Model state: linear pixel index within the frame, completed frames,
  // pending origin pulse, and the decode seen one enabled cycle earlier.
  int       mp[2]    = '{0, 0};
  int       mfc[2]   = '{0, 0};
  bit       mpend[2] = '{1'b0, 1'b0};
  logic [2:0] mdly[2] = '{3'b011, 3'b011};

  function automatic logic [2:0] decode(input int i, input int p);
    int xx, yy;
    xx = p % ht[i];
    yy = p / ht[i];
    return {(xx < hv[i]) && (yy < vv[i]),
            !((xx >= hv[i] + hf[i]) && (xx < hv[i] + hf[i] + hs[i])),
            !((yy >= vv[i] + vf[i]) && (yy < vv[i] + vf[i] + vs[i]))};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mp[i] = 0; mfc[i] = 0; mpend[i] = 1'b0; mdly[i] = 3'b011;
      end else if (ena) begin
        mdly[i]  = decode(i, mp[i]);
        mpend[i] = (mp[i] == ht[i] * vt[i] - 1);
        mp[i]    = (mp[i] + 1) % (ht[i] * vt[i]);
        if (mpend[i]) mfc[i] = (mfc[i] + 1) % 256;
      end
    end
  end

  function automatic logic [31:0] exp_vec(input int i);
    logic [2:0] syn;
    syn = LAG ? mdly[i] : decode(i, mp[i]);
    return {10'(mp[i] % ht[i]), 10'(mp[i] / ht[i]), syn,
            mpend[i] && (ena == 1'b1), 8'(mfc[i])};
  endfunction

  function automatic logic [31:0] act_vec(input int i);
    if (i == 0) return {d_x, d_y, d_act, d_hs, d_vs, d_fs, d_fc};
    return {s_x, s_y, s_act, s_hs, s_vs, s_fs, s_fc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  // (fields: x, y, active, hsync, vsync, frame_start, frame_count).
  always @(negedge clk) begin
    chk("model_default", act_vec(0), exp_vec(0));
    chk("model_small", act_vec(1), exp_vec(1));
  end

  // Bounded wait until instance i shows (tx,ty); ty<0 matches any line.
  task automatic wait_pos(input int i, input int tx, input int ty, input int budget);
    logic [31:0] v;
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      v = act_vec(i);
      if (v[31:22] == 10'(tx) && (ty < 0 || v[21:12] == 10'(ty))) found = 1'b1;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pos inst%0d: (%0d,%0d) not reached, at (%0d,%0d)",
               i, tx, ty, v[31:22], v[21:12]);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_hsync", d_hs, 1);
    chk("rst_vsync", d_vs, 1);
    chk("rst_fs", d_fs, 0);
    chk("rst_fc", d_fc, 0);
    chk("rst_active", d_act, LAG ? 0 : 1);

    // Line sweep.
    #2 rst_n = 1'b1; ena = 1'b1;
    #1 chk("release_x", d_x, 0);
    wait_pos(0, 640, 0, 1000);
    chk("active_x640", d_act, LAG ? 1 : 0);
    @(negedge clk) chk("active_x641", d_act, 0);
    wait_pos(0, 656, 0, 100);
    chk("hsync_x656", d_hs, LAG ? 1 : 0);
    @(negedge clk) chk("hsync_x657", d_hs, 0);
    wait_pos(0, 751, 0, 200);
    chk("hsync_x751", d_hs, 0);
    @(negedge clk) chk("hsync_x752", d_hs, LAG ? 0 : 1);
    wait_pos(0, 799, 0, 100);
    chk("wrap_y_before", d_y, 0);
    @(negedge clk);
    chk("wrap_x", d_x, 0);
    chk("wrap_y_after", d_y, 1);

    // Enable stall.
    wait_pos(0, 300, 1, 1000);
    #2 ena = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_x", d_x, 300);
      chk("stall_y", d_y, 1);
      chk("stall_fs", s_fs, 0);
      chk("stall_fc", d_fc, 0);
    end
    #2 ena = 1'b1;
    @(negedge clk) chk("resume_x", d_x, 301);

    // Randomized enable against the model.
    repeat (3000) begin
      @(negedge clk);
      #2 ena = ($urandom_range(0, 3) != 0);
    end
    #1 ena = 1'b1;

    // Reset mid-operation.
    wait_pos(0, 400, -1, 2000);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x", d_x, 0);
    chk("midrst_y", d_y, 0);
    chk("midrst_hsync", d_hs, 1);
    chk("midrst_vsync", d_vs, 1);
    chk("midrst_fs", d_fs, 0);
    chk("midrst_small_fc", s_fc, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("no_pulse_default", d_fs, 0);
      chk("no_pulse_small", s_fs, 0);
    end

    // Vsync window on the small raster (sync lines 4..5).
    wait_pos(1, 7, 3, 200);
    chk("vsync_y3", s_vs, 1);
    @(negedge clk) chk("vsync_y4_x0", s_vs, LAG ? 1 : 0);
    @(negedge clk) chk("vsync_y4_x1", s_vs, 0);
    wait_pos(1, 7, 5, 200);
    chk("vsync_y5_x7", s_vs, 0);
    @(negedge clk) chk("vsync_y6_x0", s_vs, LAG ? 0 : 1);

    // Frame wrap.
    wait_pos(1, 7, 6, 200);
    chk("pre_wrap_fs", s_fs, 0);
    chk("pre_wrap_fc", s_fc, 0);
    @(negedge clk);
    chk("wrap_origin", {s_x, s_y}, 0);
    chk("wrap_fs", s_fs, 1);
    chk("wrap_fc", s_fc, 1);
    @(negedge clk);
    chk("post_wrap_fs", s_fs, 0);
    chk("post_wrap_fc", s_fc, 1);

    // frame_count rollover, random enable on the way.
    for (int n = 0; n < 40000 && s_fc != 8'd255; n++) begin
      @(negedge clk);
      #2 ena = ($urandom_range(0, 3) != 0);
    end
    #1 ena = 1'b1;
    wait_pos(1, 7, 6, 200);
    chk("roll_pre_fc", s_fc, 255);
    @(negedge clk);
    chk("roll_fc", s_fc, 0);
    chk("roll_fs", s_fs, 1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
